ahbl_sram_ctrl: RTL
===================

AHBL_SRAM_CTRL -- requirements
Module: ahbl_sram_ctrl

Interface
REQ-001 SHALL have parameter AW, default 12, meaning SRAM word-address width (2^AW x 32-bit words).
REQ-002 SHALL have port HCLK  input  1  the only clock; all state changes on rising edge.
REQ-003 SHALL have port HRESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have AHB-Lite responder inputs: HSEL 1, HADDR 32, HTRANS 2, HWRITE 1, HSIZE 3, HWDATA 32, HREADY 1 (bus ready).
REQ-005 SHALL have AHB-Lite responder outputs: HREADYOUT 1, HRESP 1 (0 = OKAY, 1 = ERROR), HRDATA 32.
REQ-006 SHALL have SRAM outputs: SRAMCS 1, SRAMWEN 4 (per-byte write enables), SRAMADDR AW (word address), SRAMWDATA 32.
REQ-007 SHALL have SRAM input SRAMRDATA 32, valid one cycle after a cycle with SRAMCS=1 and SRAMWEN=0.

Function
REQ-008 SHALL accept a transfer when HSEL=1, HREADY=1 and HTRANS[1]=1; IDLE/BUSY or unselected transfers SHALL get a zero-wait OKAY response with no SRAM access.
REQ-009 SHALL treat the transfer as legal only if HSIZE<=2 and the address is aligned: HSIZE=1 needs HADDR[0]=0, HSIZE=2 needs HADDR[1:0]=0.
REQ-010 SHALL derive byte lanes: HSIZE=0 -> 1 lane at HADDR[1:0]; HSIZE=1 -> 2 lanes at HADDR[1]*2; HSIZE=2 -> 4'b1111.
REQ-011 SHALL use word address HADDR[AW+1:2] and ignore HADDR[31:AW+2].
REQ-012 SHALL implement states IDLE, RDATA, WDATA, RWAIT, ERR1, ERR2.
REQ-013 SHALL issue a legal read in its address phase (SRAMCS=1, SRAMWEN=0, SRAMADDR=HADDR word) when the SRAM port is free, and then enter RDATA.
REQ-014 In RDATA, SHALL drive HREADYOUT=1, HRESP=0 and HRDATA=SRAMRDATA, giving zero-wait reads.
REQ-015 SHALL register the address and lanes of a legal write and enter WDATA; in WDATA it SHALL drive SRAMCS=1, SRAMWEN=lanes, SRAMADDR=registered word and SRAMWDATA=HWDATA, with HREADYOUT=1.
REQ-016 If a read address phase coincides with WDATA (port busy), SHALL register the read address and enter RWAIT.
REQ-017 In RWAIT, SHALL issue the read from the registered address with HREADYOUT=0, then enter RDATA; this costs exactly one wait state.
REQ-018 A write address phase during WDATA or RDATA SHALL need no stall (back-to-back writes are zero-wait).
REQ-019 An illegal transfer SHALL make no SRAM access and enter ERR1.
REQ-020 SHALL drive HRESP=1 with HREADYOUT=0 in ERR1, then HRESP=1 with HREADYOUT=1 in ERR2, then return to IDLE.
REQ-021 A transfer presented during ERR2 SHALL be sampled normally.
REQ-022 HRDATA SHALL be 32'h0 in every state other than RDATA.
REQ-023 Outside the cases above, SRAMCS and SRAMWEN SHALL be 0.
REQ-024 A read hazard SHALL not exist, because writes complete in WDATA before any later read is issued.

Reset
REQ-025 While HRESET=1, SHALL force SRAMCS=0 and SRAMWEN=0 combinationally.
REQ-026 At a clock edge with HRESET=1, SHALL enter IDLE.
REQ-027 After reset, outputs SHALL be HREADYOUT=1, HRESP=0 and HRDATA=0, and all registered address/lane state SHALL be 0.
REQ-028 Reset asserted mid-write (WDATA) SHALL suppress that write and drop any pending RWAIT read.

Verification
REQ-029 Word write 32'hDEADBEEF to 0x0000_0010, then word read of 0x10 -> SRAM written at word 4 with WEN=4'hF; read returns 32'hDEADBEEF; the read gets exactly one wait state (RWAIT).
REQ-030 Byte write 8'hA5 to 0x13 over a word holding 32'h11223344 -> SRAMWEN=4'b1000; later read returns 32'hA5223344 with zero wait states when issued after an idle cycle.
REQ-031 Halfword write to 0x21 (misaligned) -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1; no SRAMCS pulse; the following legal read is OKAY.
REQ-032 Eight back-to-back word writes then eight back-to-back reads of 0x100..0x11C -> writes take no wait states; only the first read stalls (1 cycle); data matches.
REQ-033 HTRANS=BUSY, and HSEL=0 with HTRANS=NONSEQ -> HREADYOUT=1, HRESP=0, SRAMCS=0.
REQ-034 Assert HRESET during WDATA of a write of 32'h12345678 to 0x40 -> SRAMWEN=0 that cycle; state IDLE after the edge; later read of 0x40 returns the prior contents.

Source files
------------

// File: rtl/ahbl_sram_ctrl_if.sv
// AHB-Lite bus bundle seen by the SRAM controller.
// The master side also drives HREADY, standing in for the interconnect.
interface ahbl_sram_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahbl_sram_ctrl.sv
// AHB-Lite responder for a single-port 32-bit synchronous SRAM.
// Reads are zero-wait unless the SRAM port is busy with a write data phase.
module ahbl_sram_ctrl #(
    parameter int AW = 12
) (
    input  logic            HCLK,
    input  logic            HRESET,
    ahbl_sram_ctrl_if.slave bus,
    output logic            SRAMCS,
    output logic [3:0]      SRAMWEN,
    output logic [AW-1:0]   SRAMADDR,
    output logic [31:0]     SRAMWDATA,
    input  logic [31:0]     SRAMRDATA
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RDATA = 3'd1,
        WDATA = 3'd2,
        RWAIT = 3'd3,
        ERR1  = 3'd4,
        ERR2  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    lanes_q, lanes_d;

    logic          accept_s;
    logic          legal_s;
    logic [3:0]    lanes_s;
    logic [AW-1:0] word_s;
    logic          unused_s;

    assign unused_s = ^{bus.HADDR[31:AW+2], bus.HTRANS[0]};

    // Address-phase decode: acceptance, alignment legality and byte lanes.
    always_comb begin
        accept_s = bus.HSEL & bus.HREADY & bus.HTRANS[1];
        word_s   = bus.HADDR[AW+1:2];
        case (bus.HSIZE)
            3'd0: begin
                legal_s = 1'b1;
                lanes_s = 4'b0001 << bus.HADDR[1:0];
            end
            3'd1: begin
                legal_s = ~bus.HADDR[0];
                lanes_s = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                legal_s = (bus.HADDR[1:0] == 2'b00);
                lanes_s = 4'b1111;
            end
            default: begin
                legal_s = 1'b0;
                lanes_s = 4'b0000;
            end
        endcase
    end

    // Next state, bus response and SRAM port drive.
    always_comb begin
        state_d       = IDLE;
        addr_d        = addr_q;
        lanes_d       = lanes_q;
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 1'b0;
        bus.HRDATA    = 32'h0000_0000;
        SRAMCS        = 1'b0;
        SRAMWEN       = 4'b0000;
        SRAMADDR      = addr_q;
        SRAMWDATA     = 32'h0000_0000;
        case (state_q)
            ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = 1'b1;
                state_d       = ERR2;
            end
            RWAIT: begin
                bus.HREADYOUT = 1'b0;
                SRAMCS        = 1'b1;
                state_d       = RDATA;
            end
            default: begin
                // Data-phase side of IDLE, RDATA, WDATA and ERR2.
                if (state_q == RDATA) begin
                    bus.HRDATA = SRAMRDATA;
                end else if (state_q == ERR2) begin
                    bus.HRESP = 1'b1;
                end else if (state_q == WDATA) begin
                    SRAMCS    = 1'b1;
                    SRAMWEN   = lanes_q;
                    SRAMWDATA = bus.HWDATA;
                end else begin
                    bus.HRDATA = 32'h0000_0000;
                end
                // A read colliding with a write data phase must wait for the port.
                if (accept_s) begin
                    if (!legal_s) begin
                        state_d = ERR1;
                    end else if (bus.HWRITE) begin
                        addr_d  = word_s;
                        lanes_d = lanes_s;
                        state_d = WDATA;
                    end else if (state_q == WDATA) begin
                        addr_d  = word_s;
                        state_d = RWAIT;
                    end else begin
                        SRAMCS   = 1'b1;
                        SRAMADDR = word_s;
                        state_d  = RDATA;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
        if (HRESET) begin
            SRAMCS  = 1'b0;
            SRAMWEN = 4'b0000;
        end else begin
            SRAMCS  = SRAMCS;
        end
    end

    // State and registered address/lane flops.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lanes_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lanes_q <= lanes_d;
        end
    end
endmodule
